spi_slave: RTL and testbench

SPI responder for the digitizer's SPI bus, mode CPOL=0/CPHA=1: data is launched on the SCK rising edge and captured on the SCK falling edge. The block exchanges 8-bit bytes with an external SPI master. It oversamples `ss_n`, `sck` and `mosi` in the local `clk` domain, with no SCK-clocked logic. It also offers a one-entry transmit buffer with a valid/ready handshake and a one-cycle receive strobe to the digitizer control logic.

---
 rtl/spi_pkg.sv | 13 +
 rtl/sync_edge.sv | 33 +++
 rtl/spi_slave.sv | 138 +++++++++++++
 tb/tb_spi_slave.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM encoding, byte geometry, idle fill byte.
package spi_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = $clog2(BYTE_W);
    localparam logic [BYTE_W-1:0] DEFAULT_TX_VAL = 8'hFF;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, with rise/fall pulses on the synchronized level.
// Latency: STAGES edges to dout; pulses are combinational from dout and one extra register.
// Backpressure: none, free-running sampler.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign dout = chain[STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-1 responder oversampled in clk, with a one-entry transmit buffer and receive strobe.
// Latency: pin edge to action SYNC_STAGES+1 clk edges; new_data one cycle after the 8th SCK fall is seen.
// Backpressure: tx_ready low while the buffer holds a byte; empty buffer at load sends DEFAULT_TX.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] DEFAULT_TX  = DEFAULT_TX_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] data_out,
    output logic              new_data,
    output logic              tx_underrun,
    output logic              busy
);

    logic ss_s, ss_rise, ss_fall;
    logic sck_lvl_unused, sck_rise, sck_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_s;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .din(ss_n),
        .dout(ss_s), .rise(ss_rise), .fall(ss_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .din(sck),
        .dout(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) mosi_chain <= '0;
        else     mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [BYTE_W-1:0]  shift_out, shift_in, buf_data;
    logic               buf_full;
    logic               frame_start, byte_done, load, push;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        byte_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_nxt   = ST_ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) state_nxt = ST_IDLE;
                else         byte_done = sck_fall && (bit_cnt == CNT_W'(BYTE_W - 1));
            end
        endcase
    end

    assign load     = frame_start | byte_done;
    assign push     = tx_valid & ~buf_full;
    assign tx_ready = ~buf_full;
    assign busy     = (state == ST_ACTIVE);
    assign miso_oe  = ~ss_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            shift_out   <= '0;
            shift_in    <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            miso        <= 1'b0;
            data_out    <= '0;
            new_data    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            new_data    <= 1'b0;
            tx_underrun <= 1'b0;

            if (push) begin
                buf_data <= tx_data;
                buf_full <= 1'b1;
            end

            if (frame_start) begin
                bit_cnt <= '0;
            end else if (state == ST_ACTIVE) begin
                if (ss_rise) begin
                    // Deselect drops any partial byte; buffered tx byte stays for the next frame.
                    bit_cnt <= '0;
                    miso    <= 1'b0;
                end else begin
                    if (sck_rise) begin
                        miso      <= shift_out[BYTE_W-1];
                        shift_out <= {shift_out[BYTE_W-2:0], 1'b0};
                    end
                    if (sck_fall) begin
                        shift_in <= {shift_in[BYTE_W-2:0], mosi_s};
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                    if (byte_done) begin
                        data_out <= {shift_in[BYTE_W-2:0], mosi_s};
                        new_data <= 1'b1;
                    end
                end
            end

            // A push can only coincide with a load when the buffer was empty, so no pop conflict.
            if (load) begin
                if (buf_full) begin
                    shift_out <= buf_data;
                    buf_full  <= 1'b0;
                end else begin
                    shift_out   <= DEFAULT_TX;
                    tx_underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as an fclk/8 mode-1 master and checks with immediate assertions.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst, ss_n, sck, mosi, tx_valid;
    logic [7:0] tx_data;
    logic       miso, miso_oe, tx_ready, new_data, tx_underrun, busy;
    logic [7:0] data_out;

    spi_slave #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
        .clk(clk), .rst(rst), .ss_n(ss_n), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .data_out(data_out), .new_data(new_data), .tx_underrun(tx_underrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nd_cnt = 0;
    int ur_cnt = 0;
    int acc_cnt = 0;
    logic [7:0] nd_last = 8'h00;

    always @(negedge clk) begin
        if (new_data === 1'b1) begin
            nd_cnt++;
            nd_last = data_out;
        end
        if (tx_underrun === 1'b1) ur_cnt++;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) acc_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            sck  = 1'b1;
            tick(4);
            mi   = {mi[6:0], miso};
            sck  = 1'b0;
            tick(4);
        end
    endtask

    task automatic push(input logic [7:0] d);
        bit ok;
        ok       = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            ok = tx_ready;
            tick(1);
        end
        tx_valid = 1'b0;
        chk("push_accepted", 32'(ok), 32'd1);
    endtask

    initial begin
        logic [7:0] mi;
        int acc0;

        rst = 1'b1; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
        tick(3);
        chk("reset_outputs", 32'({miso, miso_oe, tx_ready, new_data, tx_underrun, busy, data_out}),
            32'({6'b001000, 8'h00}));
        rst = 1'b0;
        tick(2);

        // Single frame: A5 out, 3C in; a second byte keeps the reload from underrunning.
        push(8'hA5);
        ss_n = 1'b0;
        tick(4);
        chk("frame_busy_oe", 32'({busy, miso_oe, tx_ready}), 32'b111);
        push(8'h5C);
        xfer(8'h3C, 8, mi);
        chk("single_miso", 32'(mi), 32'hA5);
        chk("single_nd_cnt", nd_cnt, 1);
        chk("single_data_out", 32'(data_out), 32'h3C);
        chk("single_no_underrun", ur_cnt, 0);
        ss_n = 1'b1;
        tick(4);
        chk("deselect_idle", 32'({busy, miso_oe, miso}), 32'b000);

        // Back-to-back bytes in one frame.
        push(8'h11);
        ss_n = 1'b0;
        tick(4);
        chk("b2b_ready_after_start", 32'(tx_ready), 32'd1);
        push(8'h22);
        xfer(8'hC3, 8, mi);
        chk("b2b_miso0", 32'(mi), 32'h11);
        chk("b2b_rx0", 32'(nd_last), 32'hC3);
        chk("b2b_ready_after_byte0", 32'(tx_ready), 32'd1);
        chk("b2b_no_underrun_byte0", ur_cnt, 0);
        xfer(8'h5A, 8, mi);
        chk("b2b_miso1", 32'(mi), 32'h22);
        chk("b2b_rx1", 32'(nd_last), 32'h5A);
        chk("b2b_nd_cnt", nd_cnt, 3);
        chk("b2b_reload_underrun", ur_cnt, 1);
        ss_n = 1'b1;
        tick(4);

        // Underrun: frame with empty buffer.
        ss_n = 1'b0;
        tick(4);
        chk("ur_at_start", ur_cnt, 2);
        xfer(8'h81, 8, mi);
        chk("ur_miso", 32'(mi), 32'hFF);
        chk("ur_rx", 32'(data_out), 32'h81);
        chk("ur_nd_cnt", nd_cnt, 4);
        ss_n = 1'b1;
        tick(4);

        // Handshake: hold valid against a full buffer.
        push(8'h96);
        tx_data  = 8'h4B;
        tx_valid = 1'b1;
        acc0     = acc_cnt;
        tick(10);
        chk("hs_blocked_ready", 32'(tx_ready), 32'd0);
        chk("hs_blocked_acc", acc_cnt - acc0, 0);
        ss_n = 1'b0;
        tick(4);
        tx_valid = 1'b0;
        chk("hs_one_transfer", acc_cnt - acc0, 1);
        chk("hs_full_again", 32'(tx_ready), 32'd0);
        xfer(8'hE7, 8, mi);
        chk("hs_miso", 32'(mi), 32'h96);
        chk("hs_rx", 32'(data_out), 32'hE7);

        // Mid-byte deselect after 5 falls; buffered 69 must survive.
        push(8'h69);
        xfer(8'h18, 5, mi);
        chk("partial_miso", 32'(mi), 32'h09);
        ss_n = 1'b1;
        tick(6);
        chk("partial_nd_cnt", nd_cnt, 5);
        chk("partial_data_out", 32'(data_out), 32'hE7);
        chk("partial_idle", 32'({miso_oe, busy, miso, tx_ready}), 32'b0000);
        ss_n = 1'b0;
        tick(4);
        chk("partial_no_ur_start", ur_cnt, 3);
        xfer(8'hD2, 8, mi);
        chk("after_partial_miso", 32'(mi), 32'h69);
        chk("after_partial_rx", 32'(data_out), 32'hD2);
        chk("after_partial_nd", nd_cnt, 6);
        ss_n = 1'b1;
        tick(4);

        // Reset mid-frame with the buffer full.
        push(8'h33);
        ss_n = 1'b0;
        tick(4);
        push(8'h44);
        xfer(8'h0F, 3, mi);
        rst = 1'b1;
        tick(1);
        chk("midreset_outputs", 32'({miso, miso_oe, tx_ready, new_data, tx_underrun, busy, data_out}),
            32'({6'b001000, 8'h00}));
        ss_n = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1; sck = 1'b1; tick(4);
            sck = 1'b0; tick(4);
        end
        chk("idle_sck_ignored", 32'({busy, miso, new_data, data_out}), 32'h000);
        chk("idle_sck_nd", nd_cnt, 6);
        ss_n = 1'b0;
        tick(4);
        chk("post_reset_ur", ur_cnt, 5);
        xfer(8'h7E, 8, mi);
        chk("post_reset_miso", 32'(mi), 32'hFF);
        chk("post_reset_rx", 32'(data_out), 32'h7E);
        chk("post_reset_nd", nd_cnt, 7);
        ss_n = 1'b1;
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
